ov7670_capture: RTL and testbench



---
 rtl/ov7670_capture_pkg.sv | 14 +
 rtl/ov7670_capture.sv | 100 ++++++++++
 tb/tb_ov7670_capture.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ov7670_capture_pkg.sv
// ov7670_capture_pkg: shared widths, default geometry, RGB565 layout and capture states.
package ov7670_capture_pkg;
  localparam int X_W = 10;
  localparam int Y_W = 9;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int SKIP_DEF = 2;
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;
  typedef enum logic [1:0] {WAIT_SYNC, VBLANK, ACTIVE} state_t;
endpackage

// File: rtl/ov7670_capture.sv
// ov7670_capture: turns the OV7670 RGB565 byte stream into X/Y-tagged 16-bit pixel write strobes.
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int SKIP_FRAMES = SKIP_DEF
) (
  input  logic           pixelClk,
  input  logic           reset,
  input  logic           vsync,
  input  logic           href,
  input  logic [7:0]     camData,
  output logic           writeEn,
  output logic [X_W-1:0] outX,
  output logic [Y_W-1:0] outY,
  output logic [15:0]    pixelOut,
  output logic           frameDone,
  output logic [7:0]     frameCount,
  output logic           lineErr
);
  localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE);
  localparam logic [7:0] SKIP_N = 8'(SKIP_FRAMES);
  state_t state, stateNext;
  logic vsyncQ, hrefQ, byteSel, lineOvf;
  logic [7:0] hiByte, skipCnt;
  logic [X_W-1:0] xCnt;
  logic [Y_W-1:0] yCnt;
  logic vsyncRise, hrefFall, frameEnd, qual;
  assign vsyncRise = vsync & ~vsyncQ;
  assign hrefFall = hrefQ & ~href;
  assign frameEnd = (state == ACTIVE) & vsyncRise;
  assign qual = (xCnt < X_MAX) & (yCnt < Y_MAX) & (skipCnt >= SKIP_N);
  always_comb begin
    stateNext = state;
    stateNext = (state == WAIT_SYNC) ? (vsyncRise ? VBLANK : WAIT_SYNC) :
                (state == VBLANK)    ? (vsync ? VBLANK : ACTIVE) :
                                       (vsyncRise ? VBLANK : ACTIVE);
  end
  always_ff @(posedge pixelClk or posedge reset)
    if (reset) state <= WAIT_SYNC;
    else state <= stateNext;
  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      vsyncQ <= 1'b0;
      hrefQ <= 1'b0;
      byteSel <= 1'b0;
      lineOvf <= 1'b0;
      hiByte <= '0;
      skipCnt <= '0;
      xCnt <= '0;
      yCnt <= '0;
      writeEn <= 1'b0;
      outX <= '0;
      outY <= '0;
      pixelOut <= '0;
      frameDone <= 1'b0;
      frameCount <= '0;
      lineErr <= 1'b0;
    end else begin
      vsyncQ <= vsync;
      hrefQ <= href;
      writeEn <= 1'b0;
      frameDone <= 1'b0;
      if (frameEnd) begin
        frameDone <= 1'b1;
        frameCount <= frameCount + 8'd1;
        skipCnt <= (skipCnt == 8'hFF) ? skipCnt : skipCnt + 8'd1;
        if (href && xCnt != '0) lineErr <= 1'b1;
        xCnt <= '0;
        yCnt <= '0;
        byteSel <= 1'b0;
        lineOvf <= 1'b0;
      end else if (state == ACTIVE && href) begin
        byteSel <= ~byteSel;
        if (!byteSel) hiByte <= camData;
        else begin
          if (qual) begin
            writeEn <= 1'b1;
            pixelOut <= {hiByte, camData};
            outX <= xCnt;
            outY <= yCnt;
          end
          // a pair landing on a saturated column marks the line as too long
          if (xCnt == X_MAX) lineOvf <= 1'b1;
          else xCnt <= xCnt + 1'b1;
        end
      end else if (state == ACTIVE && hrefFall) begin
        if (xCnt != '0 && yCnt != Y_MAX) yCnt <= yCnt + 1'b1;
        // only lines that delivered bytes inside ACTIVE are judged
        if ((xCnt != '0) || byteSel)
          lineErr <= lineErr | (xCnt != X_MAX) | byteSel | lineOvf;
        xCnt <= '0;
        byteSel <= 1'b0;
        lineOvf <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: directed byte-stream stimulus with a queued pixel scoreboard on a small 8x4 geometry.
module tb_ov7670_capture;
  localparam int H = 8;
  localparam int V = 4;
  typedef struct {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [15:0] p;
  } exp_t;
  logic pixelClk = 1'b0;
  logic reset, vsync, href;
  logic [7:0] camData;
  logic writeEn, frameDone, lineErr;
  logic [9:0] outX;
  logic [8:0] outY;
  logic [15:0] pixelOut;
  logic [7:0] frameCount;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int doneCnt = 0;
  int base = 0;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(2)) dut (
    .pixelClk(pixelClk), .reset(reset), .vsync(vsync), .href(href), .camData(camData),
    .writeEn(writeEn), .outX(outX), .outY(outY), .pixelOut(pixelOut),
    .frameDone(frameDone), .frameCount(frameCount), .lineErr(lineErr)
  );

  always #5 pixelClk = ~pixelClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge pixelClk) begin
    exp_t e;
    if (frameDone) doneCnt++;
    if (writeEn) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL strobe: unexpected writeEn x=%0d y=%0d pix=%h", outX, outY, pixelOut);
      end else begin
        e = q.pop_front();
        check("outX", 32'(outX), 32'(e.x));
        check("outY", 32'(outY), 32'(e.y));
        check("pixelOut", 32'(pixelOut), 32'(e.p));
      end
    end
  end

  task automatic tick();
    @(posedge pixelClk);
    #1;
  endtask

  task automatic vsyncPulse();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic line(input int n, input bit extra, input logic [7:0] hi, input logic [7:0] lo,
                      input int y, input bit on);
    logic [7:0] lp;
    href = 1'b1;
    for (int p = 0; p < n; p++) begin
      camData = hi;
      tick();
      lp = lo + 8'(p);
      camData = lp;
      if (on && p < H) q.push_back('{10'(p), 9'(y), {hi, lp}});
      tick();
    end
    if (extra) begin
      camData = hi;
      tick();
    end
    href = 1'b0;
    camData = '0;
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; href = 1'b0; camData = '0;
    repeat (3) tick();
    check("rst writeEn", 32'(writeEn), 0);
    check("rst outX", 32'(outX), 0);
    check("rst outY", 32'(outY), 0);
    check("rst pixelOut", 32'(pixelOut), 0);
    check("rst frameDone", 32'(frameDone), 0);
    check("rst frameCount", 32'(frameCount), 0);
    check("rst lineErr", 32'(lineErr), 0);
    reset = 1'b0;
    tick();
    line(8, 0, 8'h12, 8'h34, 0, 0);
    check("presync lineErr", 32'(lineErr), 0);
    for (int f = 0; f < 2; f++) begin
      vsyncPulse();
      for (int y = 0; y < V; y++) line(8, 0, 8'h55, 8'h00, y, 0);
    end
    vsyncPulse();
    check("skip frameCount", 32'(frameCount), 2);
    check("skip done", 32'(doneCnt - base), 2);
    line(8, 0, 8'hF8, 8'h1F, 0, 1);
    line(8, 0, 8'h07, 8'hE0, 1, 1);
    line(8, 0, 8'h00, 8'h1F, 2, 1);
    line(8, 0, 8'hAB, 8'hC0, 3, 1);
    line(8, 0, 8'hEE, 8'h00, 4, 0);
    check("hold outX", 32'(outX), 7);
    check("hold outY", 32'(outY), 3);
    check("hold pixelOut", 32'(pixelOut), 32'h0000ABC7);
    vsyncPulse();
    check("f2 frameCount", 32'(frameCount), 3);
    check("f2 done", 32'(doneCnt - base), 3);
    check("f2 lineErr", 32'(lineErr), 0);
    check("f2 drain", 32'(q.size()), 0);
    line(10, 0, 8'h11, 8'h00, 0, 1);
    check("long outX", 32'(outX), 7);
    check("long pixelOut", 32'(pixelOut), 32'h00001107);
    check("long lineErr", 32'(lineErr), 1);
    line(8, 0, 8'h22, 8'h00, 1, 1);
    check("next outY", 32'(outY), 1);
    href = 1'b1;
    camData = 8'h33;
    tick();
    reset = 1'b1;
    #1;
    check("mid writeEn", 32'(writeEn), 0);
    check("mid outX", 32'(outX), 0);
    check("mid outY", 32'(outY), 0);
    check("mid pixelOut", 32'(pixelOut), 0);
    check("mid frameCount", 32'(frameCount), 0);
    check("mid lineErr", 32'(lineErr), 0);
    href = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    base = doneCnt;
    tick();
    line(8, 0, 8'h44, 8'h00, 0, 0);
    repeat (3) vsyncPulse();
    check("rs frameCount", 32'(frameCount), 2);
    check("rs done", 32'(doneCnt - base), 2);
    check("rs lineErr", 32'(lineErr), 0);
    line(8, 1, 8'h66, 8'h10, 0, 1);
    check("odd lineErr", 32'(lineErr), 1);
    check("odd outX", 32'(outX), 7);
    repeat (3) tick();
    check("final drain", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
